// File: rtl/pwm_wb_ctrl_if.sv
// Wishbone classic slave bus bundle for pwm_wb_ctrl.
//   wb_adr_i  12  bit11=0 pwm window (bits 10:0 forwarded), bit11=1 control reg
//   wb_dat_i  16  write data
//   wb_we_i    1  1=write, 0=read
//   wb_stb_i   1  strobe
//   wb_cyc_i   1  bus cycle
//   wb_ack_o   1  one-cycle acknowledge
//   wb_dat_o  16  read data
// master: the bus initiator; slave: pwm_wb_ctrl.
interface pwm_wb_ctrl_if;
    logic [11:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic [15:0] wb_dat_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/pwm_wb_ctrl.sv
// pwm_wb_ctrl: feeds the pwm block's CPU write port from a Wishbone classic
// slave, and runs an init sequence (delay table, optional pixmap clear,
// enable key) after reset or on software request.
// Ports:
//   cpu_clk    sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   wb         Wishbone slave bundle (pwm_wb_ctrl_if.slave)
//   pwm_addr   11-bit pwm write address   (registered)
//   pwm_din    16-bit pwm write data      (registered)
//   pwm_we     one-cycle write pulse      (registered)
//   init_busy  high while init writes are being presented
module pwm_wb_ctrl #(
    parameter logic [15:0] DELAY_BASE   = 16'd4,
    parameter int unsigned DELAY_SHIFT  = 4,
    parameter bit          CLEAR_PIXMAP = 1'b1,
    parameter bit          AUTO_INIT    = 1'b1
) (
    input  logic          cpu_clk,
    input  logic          reset_n,
    pwm_wb_ctrl_if.slave  wb,
    output logic [10:0]   pwm_addr,
    output logic [15:0]   pwm_din,
    output logic          pwm_we,
    output logic          init_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TBL  = 2'd1,
        ST_CLR  = 2'd2,
        ST_EN   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic        auto_pend_q, auto_pend_d;
    logic        done_q, done_d;
    logic        ack_q, ack_d;
    logic [15:0] rdat_q, rdat_d;
    logic [10:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;

    logic        req;
    logic        is_ctrl;
    logic        fsm_idle;
    logic        accept;
    logic        start;

    // Gamma-shaped delay entry: base + (i*i >> shift), saturated to 16 bits.
    function automatic logic [15:0] delay_entry(input logic [7:0] i);
        logic [15:0] sq;
        logic [16:0] sum;
        sq  = {8'd0, i} * {8'd0, i};
        sum = {1'b0, DELAY_BASE} + {1'b0, (sq >> DELAY_SHIFT)};
        delay_entry = sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Request decode. Window requests wait for IDLE so they never collide
    // with an FSM write; the control reg is served in every state.
    always_comb begin
        req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        is_ctrl  = wb.wb_adr_i[11];
        fsm_idle = (state_q == ST_IDLE);
        accept   = req & (is_ctrl | fsm_idle);
        start    = fsm_idle & (auto_pend_q | (accept & is_ctrl & wb.wb_we_i & wb.wb_dat_i[0]));
    end

    // State register and all output/bookkeeping registers.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 10'd0;
            auto_pend_q <= AUTO_INIT;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            rdat_q      <= 16'd0;
            addr_q      <= 11'd0;
            din_q       <= 16'd0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            auto_pend_q <= auto_pend_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            rdat_q      <= rdat_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; the index restarts at 0 on every state entry.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TBL;
                    idx_d   = 10'd0;
                end else begin
                    idx_d   = 10'd0;
                end
            end
            ST_TBL: begin
                if (idx_q == 10'd255) begin
                    state_d = CLEAR_PIXMAP ? ST_CLR : ST_EN;
                    idx_d   = 10'd0;
                end else begin
                    idx_d   = idx_q + 10'd1;
                end
            end
            ST_CLR: begin
                if (idx_q == 10'd1023) begin
                    state_d = ST_EN;
                    idx_d   = 10'd0;
                end else begin
                    idx_d   = idx_q + 10'd1;
                end
            end
            ST_EN: begin
                state_d = ST_IDLE;
                idx_d   = 10'd0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 10'd0;
            end
        endcase
    end

    // Output logic: the write presented next cycle, ack/read data, flags.
    // busy follows state_q so it rises and falls with the FSM's writes.
    always_comb begin
        we_d        = 1'b0;
        addr_d      = 11'd0;
        din_d       = 16'd0;
        ack_d       = accept;
        rdat_d      = 16'd0;
        busy_d      = (state_q != ST_IDLE);
        done_d      = done_q;
        auto_pend_d = auto_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (accept & ~is_ctrl & wb.wb_we_i) begin
                    we_d   = 1'b1;
                    addr_d = wb.wb_adr_i[10:0];
                    din_d  = wb.wb_dat_i;
                end else begin
                    we_d   = 1'b0;
                end
            end
            ST_TBL: begin
                we_d   = 1'b1;
                addr_d = {3'b100, idx_q[7:0]};
                din_d  = delay_entry(idx_q[7:0]);
            end
            ST_CLR: begin
                we_d   = 1'b1;
                addr_d = {1'b0, idx_q};
                din_d  = 16'd0;
            end
            ST_EN: begin
                we_d   = 1'b1;
                addr_d = 11'h755;
                din_d  = 16'h0023;
            end
            default: begin
                we_d   = 1'b0;
            end
        endcase
        // Window reads return zero: the pwm window is write-only.
        if (accept & is_ctrl & ~wb.wb_we_i) begin
            rdat_d = {14'd0, done_q, busy_q};
        end else begin
            rdat_d = 16'd0;
        end
        if (start) begin
            done_d      = 1'b0;
            auto_pend_d = 1'b0;
        end else if (state_q == ST_EN) begin
            done_d      = 1'b1;
        end else begin
            done_d      = done_q;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = rdat_q;
    assign pwm_addr    = addr_q;
    assign pwm_din     = din_q;
    assign pwm_we      = we_q;
    assign init_busy   = busy_q;

endmodule
